// File: rtl/nv_nvdla_cvif_write_cq_pkg.sv
// Shared definitions for the CVIF write context queue: thread IDs, entry layout
// and a helper that tells whether a thread ID selects a real FIFO.
package cvif_write_pkg;

  localparam int CVIF_WR_THREADS = 5;
  localparam int CQ_PD_W         = 3;
  localparam int CQ_REQ_ACK_BIT  = 0;
  localparam int CQ_LEN_LSB      = 1;
  localparam int CQ_LEN_MSB      = 2;

  typedef enum logic [2:0] {
    BDMA = 3'd0,
    SDP  = 3'd1,
    PDP  = 3'd2,
    CDP  = 3'd3,
    RBK  = 3'd4
  } cvif_thread_e;

  // IDs 5..7 name no FIFO; pushes carrying them are dropped.
  function automatic logic cq_thread_valid(input logic [2:0] id);
    return (id <= RBK);
  endfunction

endpackage

// File: rtl/nv_nvdla_cvif_write_cq_if.sv
// Bundle of the context-queue handshakes: one shared push port from the
// ingress stage and five per-thread pop ports toward the egress stage.
interface nv_nvdla_cvif_write_cq_if;
  import cvif_write_pkg::*;

  logic               cq_wr_pvld;
  logic               cq_wr_prdy;
  logic [2:0]         cq_wr_thread_id;
  logic [CQ_PD_W-1:0] cq_wr_pd;

  logic               cq_rd0_pvld;
  logic               cq_rd0_prdy;
  logic [CQ_PD_W-1:0] cq_rd0_pd;
  logic               cq_rd1_pvld;
  logic               cq_rd1_prdy;
  logic [CQ_PD_W-1:0] cq_rd1_pd;
  logic               cq_rd2_pvld;
  logic               cq_rd2_prdy;
  logic [CQ_PD_W-1:0] cq_rd2_pd;
  logic               cq_rd3_pvld;
  logic               cq_rd3_prdy;
  logic [CQ_PD_W-1:0] cq_rd3_pd;
  logic               cq_rd4_pvld;
  logic               cq_rd4_prdy;
  logic [CQ_PD_W-1:0] cq_rd4_pd;

  logic               cq_idle;

  // Ingress/egress side of the queue.
  modport master (
    output cq_wr_pvld, cq_wr_thread_id, cq_wr_pd,
    input  cq_wr_prdy,
    output cq_rd0_prdy, cq_rd1_prdy, cq_rd2_prdy, cq_rd3_prdy, cq_rd4_prdy,
    input  cq_rd0_pvld, cq_rd1_pvld, cq_rd2_pvld, cq_rd3_pvld, cq_rd4_pvld,
    input  cq_rd0_pd, cq_rd1_pd, cq_rd2_pd, cq_rd3_pd, cq_rd4_pd,
    input  cq_idle
  );

  // The queue itself.
  modport slave (
    input  cq_wr_pvld, cq_wr_thread_id, cq_wr_pd,
    output cq_wr_prdy,
    input  cq_rd0_prdy, cq_rd1_prdy, cq_rd2_prdy, cq_rd3_prdy, cq_rd4_prdy,
    output cq_rd0_pvld, cq_rd1_pvld, cq_rd2_pvld, cq_rd3_pvld, cq_rd4_pvld,
    output cq_rd0_pd, cq_rd1_pd, cq_rd2_pd, cq_rd3_pd, cq_rd4_pd,
    output cq_idle
  );

endinterface

// File: rtl/nv_nvdla_cvif_write_cq_fifo.sv
// Single-thread in-order flop FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable with all DEPTH slots in use. The head is
// read combinationally; there is no write-to-read bypass.
module nv_nvdla_cvif_write_cq_fifo
  import cvif_write_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  input  logic               wr_en,
  input  logic [CQ_PD_W-1:0] wr_pd,
  output logic               full,
  input  logic               rd_en,
  output logic [CQ_PD_W-1:0] rd_pd,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        r_wp;
  logic [AW:0]        r_rp;
  logic [CQ_PD_W-1:0] r_mem [DEPTH];
  logic               w_push;
  logic               w_pop;

  assign empty  = (r_wp == r_rp);
  assign full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  // Pushes into a full FIFO and pops from an empty one are silently ignored.
  assign w_push = wr_en & ~full;
  assign w_pop  = rd_en & ~empty;
  assign rd_pd  = r_mem[r_rp[AW-1:0]];

  // Advance write/read pointers; reset empties the FIFO at once.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // Entry storage, deliberately not reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= wr_pd;
  end

endmodule

// File: rtl/nv_nvdla_cvif_write_cq.sv
// CVIF write context queue: five per-thread FIFOs behind one shared push
// port. The thread ID steers the push and selects which full flag drives
// the push-ready; each thread pops independently.
module nv_nvdla_cvif_write_cq
  import cvif_write_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  nv_nvdla_cvif_write_cq_if.slave  cq
);

  logic [CVIF_WR_THREADS-1:0] w_wr_en;
  logic [CVIF_WR_THREADS-1:0] w_full;
  logic [CVIF_WR_THREADS-1:0] w_empty;
  logic [CVIF_WR_THREADS-1:0] w_rd_prdy;
  logic [CQ_PD_W-1:0]         w_rd_pd [CVIF_WR_THREADS];
  logic                       w_wr_prdy;

  assign w_rd_prdy = {cq.cq_rd4_prdy, cq.cq_rd3_prdy, cq.cq_rd2_prdy,
                      cq.cq_rd1_prdy, cq.cq_rd0_prdy};

  // Push-ready follows the selected thread's full flag only; unknown IDs are
  // accepted and dropped so the ingress stage never deadlocks on them.
  always_comb begin
    w_wr_prdy = 1'b1;
    for (int i = 0; i < CVIF_WR_THREADS; i++) begin
      if (cq.cq_wr_thread_id == 3'(i)) w_wr_prdy = ~w_full[i];
    end
  end

  assign cq.cq_wr_prdy = w_wr_prdy;

  genvar gi;
  generate
    for (gi = 0; gi < CVIF_WR_THREADS; gi++) begin : g_thread
      assign w_wr_en[gi] = cq.cq_wr_pvld & (cq.cq_wr_thread_id == 3'(gi));

      nv_nvdla_cvif_write_cq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .wr_en           (w_wr_en[gi]),
        .wr_pd           (cq.cq_wr_pd),
        .full            (w_full[gi]),
        .rd_en           (w_rd_prdy[gi]),
        .rd_pd           (w_rd_pd[gi]),
        .empty           (w_empty[gi])
      );
    end
  endgenerate

  assign cq.cq_rd0_pvld = ~w_empty[0];
  assign cq.cq_rd1_pvld = ~w_empty[1];
  assign cq.cq_rd2_pvld = ~w_empty[2];
  assign cq.cq_rd3_pvld = ~w_empty[3];
  assign cq.cq_rd4_pvld = ~w_empty[4];
  assign cq.cq_rd0_pd   = w_rd_pd[0];
  assign cq.cq_rd1_pd   = w_rd_pd[1];
  assign cq.cq_rd2_pd   = w_rd_pd[2];
  assign cq.cq_rd3_pd   = w_rd_pd[3];
  assign cq.cq_rd4_pd   = w_rd_pd[4];
  assign cq.cq_idle     = &w_empty;

  // A push tagged with a non-existent thread indicates an ingress bug.
  a_thread_id_legal : assert property (
    @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    cq.cq_wr_pvld |-> cq_thread_valid(cq.cq_wr_thread_id)
  ) else $warning("cvif write cq: push with unknown thread id %0d dropped",
                  cq.cq_wr_thread_id);

endmodule

// File: tb/tb_nv_nvdla_cvif_write_cq.sv
// Bench for the CVIF write context queue: directed scenarios followed by
// random traffic, all compared against per-thread reference queues.
module tb_nv_nvdla_cvif_write_cq;
  import cvif_write_pkg::*;

  localparam int DEPTH = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nv_nvdla_cvif_write_cq_if cq_if ();

  nv_nvdla_cvif_write_cq #(.DEPTH(DEPTH)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .cq              (cq_if)
  );

  logic [4:0] drv_prdy;
  logic [4:0] obs_pvld;
  logic [2:0] obs_pd [5];

  assign cq_if.cq_rd0_prdy = drv_prdy[0];
  assign cq_if.cq_rd1_prdy = drv_prdy[1];
  assign cq_if.cq_rd2_prdy = drv_prdy[2];
  assign cq_if.cq_rd3_prdy = drv_prdy[3];
  assign cq_if.cq_rd4_prdy = drv_prdy[4];
  assign obs_pvld = {cq_if.cq_rd4_pvld, cq_if.cq_rd3_pvld, cq_if.cq_rd2_pvld,
                     cq_if.cq_rd1_pvld, cq_if.cq_rd0_pvld};
  assign obs_pd[0] = cq_if.cq_rd0_pd;
  assign obs_pd[1] = cq_if.cq_rd1_pd;
  assign obs_pd[2] = cq_if.cq_rd2_pd;
  assign obs_pd[3] = cq_if.cq_rd3_pd;
  assign obs_pd[4] = cq_if.cq_rd4_pd;

  // Reference: one in-order queue of pending entries per thread.
  logic [2:0] mq [5][$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic all_empty;
    all_empty = 1'b1;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("rd%0d_pvld", n), 32'(obs_pvld[n]), 32'(mq[n].size() != 0));
      if (mq[n].size() != 0) begin
        all_empty = 1'b0;
        chk($sformatf("rd%0d_pd", n), 32'(obs_pd[n]), 32'(mq[n][0]));
      end
    end
    chk("idle", 32'(cq_if.cq_idle), 32'(all_empty));
  endtask

  // One clock of traffic: drive, check against the model, clock, update model.
  task automatic cyc(input logic pv, input logic [2:0] id, input logic [2:0] pd,
                     input logic [4:0] pop);
    logic exp_prdy;
    int   idx;
    cq_if.cq_wr_pvld      = pv;
    cq_if.cq_wr_thread_id = id;
    cq_if.cq_wr_pd        = pd;
    drv_prdy              = pop;
    #1;
    idx = int'(id);
    exp_prdy = 1'b1;
    if (idx < 5) exp_prdy = (mq[idx].size() < DEPTH);
    chk("wr_prdy", 32'(cq_if.cq_wr_prdy), 32'(exp_prdy));
    check_outputs();
    $display("txn t=%0t push=%0b id=%0d pd=%0b acc=%0b pop=%05b", $time,
             pv, id, pd, pv & exp_prdy & (idx < 5), pop);
    @(posedge clk);
    for (int n = 0; n < 5; n++)
      if (pop[n] && mq[n].size() != 0) void'(mq[n].pop_front());
    if (pv && exp_prdy && idx < 5) mq[idx].push_back(pd);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) cyc(1'b0, 3'd0, 3'd0, 5'b11111);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    cq_if.cq_wr_pvld      = 1'b0;
    cq_if.cq_wr_thread_id = 3'd0;
    cq_if.cq_wr_pd        = 3'd0;
    drv_prdy              = 5'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Reset state: every thread id sees prdy=1, all empty.
    for (int i = 0; i < 8; i++) cyc(1'b0, 3'(i), 3'd0, 5'b0);

    // Ordering on thread 2.
    cyc(1'b1, 3'd2, 3'b011, 5'b0);
    cyc(1'b1, 3'd2, 3'b101, 5'b0);
    cyc(1'b1, 3'd2, 3'b110, 5'b0);
    chk("ord_head0", 32'(obs_pd[2]), 32'h3);
    cyc(1'b0, 3'd0, 3'd0, 5'b00100);
    chk("ord_head1", 32'(obs_pd[2]), 32'h5);
    cyc(1'b0, 3'd0, 3'd0, 5'b00100);
    chk("ord_head2", 32'(obs_pd[2]), 32'h6);
    cyc(1'b0, 3'd0, 3'd0, 5'b00100);
    chk("ord_empty", 32'(obs_pvld), 32'h0);

    // Full boundary and pointer wrap on thread 4.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 3'd4, 3'(i), 5'b0);
    cyc(1'b0, 3'd0, 3'd0, 5'b0);
    cq_if.cq_wr_thread_id = 3'd4;
    #1 chk("full_prdy4", 32'(cq_if.cq_wr_prdy), 32'h0);
    cyc(1'b1, 3'd4, 3'b111, 5'b10000);
    cyc(1'b1, 3'd4, 3'b111, 5'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 3'd4, 3'd0, 5'b10000);
      cyc(1'b1, 3'd4, 3'($urandom_range(0, 7)), 5'b0);
    end
    drain();

    // Simultaneous push/pop on a thread holding one entry.
    cyc(1'b1, 3'd1, 3'b010, 5'b0);
    cyc(1'b1, 3'd1, 3'b111, 5'b00010);
    chk("simul_head", 32'(obs_pd[1]), 32'h7);
    cyc(1'b0, 3'd0, 3'd0, 5'b00010);
    chk("simul_drained", 32'(obs_pvld[1]), 32'h0);

    // Push and pop on an empty thread: pop ignored, entry kept.
    cyc(1'b1, 3'd3, 3'b100, 5'b01000);
    chk("empty_pushpop", 32'(obs_pvld[3]), 32'h1);
    drain();

    // Spurious pop and illegal thread id.
    cyc(1'b0, 3'd0, 3'd0, 5'b00001);
    cyc(1'b1, 3'd6, 3'b101, 5'b0);
    chk("illegal_idle", 32'(cq_if.cq_idle), 32'h1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic       pv;
      logic [2:0] id;
      logic [4:0] pop;
      pv  = ($urandom_range(0, 3) != 0);
      id  = pv ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      pop = 5'($urandom) & 5'($urandom);
      cyc(pv, id, 3'($urandom_range(0, 7)), pop);
    end
    drain();

    // Mid-operation reset.
    for (int t = 0; t < 5; t++)
      for (int k = 0; k < 3; k++) cyc(1'b1, 3'(t), 3'($urandom_range(0, 7)), 5'b0);
    rstn = 1'b0;
    #1;
    chk("rst_pvld", 32'(obs_pvld), 32'h0);
    chk("rst_idle", 32'(cq_if.cq_idle), 32'h1);
    for (int n = 0; n < 5; n++) mq[n].delete();
    @(negedge clk);
    rstn = 1'b1;
    cyc(1'b1, 3'd0, 3'b101, 5'b0);
    chk("post_rst_head", 32'(obs_pd[0]), 32'h5);
    cyc(1'b0, 3'd0, 3'd0, 5'b00001);
    cyc(1'b0, 3'd0, 3'd0, 5'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_cvif_write_cq.md
# nv_nvdla_cvif_write_cq

Per-thread context queue for the CVIF write path. The ingress stage pushes one 3-bit context entry, {len[1:0], require_ack}, for each AXI write request it issues, tagged with the DMA thread ID (0=BDMA, 1=SDP, 2=PDP, 3=CDP, 4=RBK). The egress stage pops the head entry of a thread when that thread's write response returns. The block holds five independent in-order FIFOs behind one shared write port and five read ports.

## Interface
Parameters:
- DEPTH, 8: entries per thread FIFO; power of two, ≥2.
- AW, $clog2(DEPTH): pointer index width (derived; not overridable).

Ports:
- nvdla_core_clk  in  1  clock; all state on rising edge.
- nvdla_core_rstn  in  1  asynchronous, active-low reset.
- cq_wr_pvld  in  1  push request.
- cq_wr_prdy  out  1  push accept.
- cq_wr_thread_id  in  3  target thread, 0..4.
- cq_wr_pd  in  3  entry: [0]=require_ack, [2:1]=len.
- cq_rdN_pvld  out  1  thread N non-empty (N=0..4).
- cq_rdN_prdy  in  1  thread N pop strobe (N=0..4).
- cq_rdN_pd  out  3  head entry of thread N (N=0..4).
- cq_idle  out  1  all five FIFOs empty.

## Operation
- Push fires on cq_wr_pvld & cq_wr_prdy. The entry is written at the write pointer of FIFO[cq_wr_thread_id], and that pointer increments.
- cq_wr_prdy = !full[cq_wr_thread_id]. It is combinational on thread_id only and is independent of cq_wr_pvld.
- Thread ID 5..7: cq_wr_prdy=1 and the push is dropped with no state change. A simulation assertion flags it.
- Pop fires on cq_rdN_prdy & cq_rdN_pvld; the read pointer of FIFO N increments.
- cq_rdN_prdy while FIFO N is empty is legal. It is ignored and causes no underflow. Egress asserts prdy on every response for the thread regardless of pvld.
- Pointers are AW+1 bits and wrap naturally.
  - empty = (wp == rp).
  - full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]).
- cq_rdN_pd = mem[rp[AW-1:0]], read combinationally from flop storage. When empty it presents the stale slot, which is don't-care.
- Same thread, same cycle push and pop:
  - Non-empty, non-full: both occur; occupancy is unchanged.
  - Full: the push is stalled (prdy=0 from the current full flag, no look-ahead) and the pop proceeds.
  - Empty: the push proceeds and the pop is ignored. There is no write-to-read bypass.
- Pushes and pops on different threads are fully independent.
- cq_idle = AND of all five empty flags.

## Timing
- Reset (async assert, sync release, all flops):
  - Pointers 0, so cq_rdN_pvld=0, cq_idle=1, cq_wr_prdy=1.
  - Storage is not reset; cq_rdN_pd is X/stale until first written.
- Push-to-visible latency is 1 cycle: an entry accepted at edge k gives cq_rdN_pvld=1 after edge k.
- Pop updates the head pd and pvld after the same edge.
- Throughput is 1 push/cycle plus up to 5 pops/cycle.
- Reset asserted mid-operation discards all entries immediately. Outputs take reset values asynchronously.

## Structure
- Shared package cvif_write_pkg:
  - CVIF_WR_THREADS=5.
  - CQ_PD_W=3.
  - Field positions CQ_REQ_ACK_BIT=0 and CQ_LEN_LSB=1 / CQ_LEN_MSB=2.
  - Thread ID constants BDMA/SDP/PDP/CDP/RBK = 0..4.
- One sub-module, nv_nvdla_cvif_write_cq_fifo:
  - Single-thread flop FIFO with parameter DEPTH.
  - Ports: wr_en, wr_pd, full, rd_en, rd_pd, empty.
  - Instantiated 5×. The top level decodes thread_id into wr_en and muxes full for cq_wr_prdy.

## Test plan
- Reset:
  - Stimulus: release reset.
  - Required: all cq_rdN_pvld=0, cq_idle=1, cq_wr_prdy=1 for every thread_id.
- Ordering:
  - Stimulus: push thread 2 pd=3'b011, 3'b101, 3'b110 on consecutive cycles, then pop one per cycle.
  - Required: cq_rd2_pd is 3'b011, 3'b101, 3'b110 in that order; pvld=0 after the third pop; other threads stay empty.
- Full boundary:
  - Stimulus: push 8 entries to thread 4 (DEPTH=8).
  - Required: cq_wr_prdy=0 for thread_id=4 and 1 for thread_id=0.
  - Stimulus: pop once with push held.
  - Required: push accepted on the next cycle; 8 entries remain.
  - Stimulus: continue past 16 pushes total.
  - Required: pointer wrap yields correct order.
- Simultaneous events:
  - Stimulus: thread 1 holds 1 entry; push thread 1 and pop thread 1 in the same cycle.
  - Required: occupancy stays 1; the head becomes the new entry.
  - Stimulus: on an empty thread 3, push and prdy in the same cycle.
  - Required: pvld=1 next cycle; the entry is not lost.
- Spurious pop and illegal ID:
  - Stimulus: cq_rd0_prdy=1 while empty.
  - Required: no state change.
  - Stimulus: push with thread_id=6.
  - Required: prdy=1, no FIFO changes, cq_idle stays 1.
- Mid-operation reset:
  - Stimulus: fill threads 0..4 with 3 entries each, then assert rstn low for 1 cycle.
  - Required: all pvld=0 and cq_idle=1 immediately; a new push after release is popped first.
